// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared types and defaults for the fetch/data memory arbiter.
package rv32_mem_pkg;

   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;
   localparam int WAIT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_DM
   } state_t;

   typedef enum logic {
      GNT_IF,
      GNT_DM
   } gnt_t;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts unanswered busy cycles and flags the cycle that
// reaches MAX_WAIT so the arbiter can abandon the access.
module mem_wait_timer
   import rv32_mem_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   logic [WAIT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + WAIT_W'(1);
   end

   // Fires on the MAX_WAIT-th unanswered cycle, so mem_req is seen exactly MAX_WAIT cycles.
   assign timeout = enable & (count == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between
// instruction fetch and data access, with a wait-cycle timeout.
module mem_arbiter
   import rv32_mem_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall,
   output logic          err
);

   state_t state, state_nx;
   gnt_t   last;
   logic   pend_if, pend_dm, grant_if, grant_dm, busy, done, timeout;

   // A requester being acked this cycle is already served, not pending again.
   assign pend_if = if_req & ~if_ack;
   assign pend_dm = dm_req & ~dm_ack;
   assign stall   = pend_if | pend_dm;
   assign busy    = state != IDLE;

   mem_wait_timer #(
      .MAX_WAIT(MAX_WAIT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (grant_if | grant_dm),
      .enable (busy & ~mem_ready),
      .timeout(timeout)
   );

   always_comb begin
      state_nx = state;
      grant_if = 1'b0;
      grant_dm = 1'b0;
      done     = 1'b0;
      if (state == IDLE) begin
         grant_dm = pend_dm & (~pend_if | (last == GNT_IF));
         grant_if = pend_if & ~grant_dm;
         state_nx = grant_dm ? BUSY_DM : grant_if ? BUSY_IF : IDLE;
      end else begin
         done     = mem_ready | timeout;
         state_nx = done ? IDLE : state;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         last  <= GNT_DM;
      end else begin
         state <= state_nx;
         if (grant_dm)
            last <= GNT_DM;
         else if (grant_if)
            last <= GNT_IF;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         err       <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if_ack <= done & (state == BUSY_IF);
         dm_ack <= done & (state == BUSY_DM);
         err    <= timeout;
         if (grant_if | grant_dm) begin
            mem_req  <= 1'b1;
            mem_we   <= grant_dm & dm_we;
            mem_addr <= grant_dm ? dm_addr : if_addr;
            // Fetches leave the last store data in place rather than toggling the bus.
            if (grant_dm)
               mem_wdata <= dm_wdata;
         end else if (done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
         end
         if (done & (state == BUSY_IF))
            if_rdata <= mem_ready ? mem_rdata : '0;
         if (done & (state == BUSY_DM))
            dm_rdata <= mem_ready ? mem_rdata : '0;
      end
   end

endmodule
